wave_gen_dac: RTL

Direct-digital-synthesis test-signal source for the digital scope. Generates square, triangle, sawtooth or DC samples and drives an 8-bit parallel DAC with a divided sample clock, using the same timing as the scope's ADC port: data changes on the falling sample-clock edge and is stable at the rising edge. It is the transmitter end of that sample interface. On the board it feeds the scope input through the DAC. In simulation it replaces the hand-written triangle stimulus. A valid/ready config port lets the control logic retune waveform, frequency and amplitude at runtime without glitches.

---
 rtl/wave_gen_dac.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/wave_gen_dac.sv
// DDS test-signal source driving an 8-bit parallel DAC with a divided sample clock.
// Samples change on the falling da_clk edge; a pending config is swapped in on a phase wrap.
module wave_gen_dac #(
    parameter int unsigned DIV_MAX   = 2,
    parameter logic [1:0]  RST_MODE  = 2'b10,
    parameter logic [31:0] RST_FWORD = 32'h0100_0000,
    parameter logic [7:0]  RST_AMP   = 8'd255
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        en,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [1:0]  cfg_mode,
    input  logic [31:0] cfg_fword,
    input  logic [7:0]  cfg_amp,
    output logic        da_clk,
    output logic [7:0]  da_data,
    output logic        wave_sync
);

    localparam int CW = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV_MAX - 1);

    localparam logic [1:0] MODE_DC     = 2'b00;
    localparam logic [1:0] MODE_SQUARE = 2'b01;
    localparam logic [1:0] MODE_TRI    = 2'b10;
    localparam logic [1:0] MODE_SAW    = 2'b11;

    // Offset-binary sample: raw shape scaled about midscale, floor via arithmetic shift.
    function automatic logic [7:0] wave_sample(input logic [1:0] mode,
                                               input logic [7:0] p,
                                               input logic [7:0] amp);
        logic [7:0]         raw;
        logic signed [8:0]  diff;
        logic signed [17:0] prod;
        case (mode)
            MODE_SQUARE: raw = p[7] ? 8'd0 : 8'd255;
            MODE_TRI:    raw = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
            MODE_SAW:    raw = p;
            default:     raw = 8'd128;
        endcase
        diff = $signed({1'b0, raw}) - 9'sd128;
        prod = diff * $signed({1'b0, amp});
        if (mode == MODE_DC) begin
            wave_sample = amp;
        end else begin
            wave_sample = 8'((prod >>> 8) + 18'sd128);
        end
    endfunction

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic          da_clk_q, da_clk_d;
    logic [31:0]   phase_q, phase_d;
    logic [1:0]    mode_q, mode_d;
    logic [31:0]   fword_q, fword_d;
    logic [7:0]    amp_q, amp_d;
    logic          pend_q, pend_d;
    logic [1:0]    pend_mode_q, pend_mode_d;
    logic [31:0]   pend_fword_q, pend_fword_d;
    logic [7:0]    pend_amp_q, pend_amp_d;
    logic [7:0]    data_q, data_d;
    logic          sync_q, sync_d;
    logic          ready_q, ready_d;

    logic          tick_s;
    logic          wrap_s;
    logic [31:0]   phase_sum_s;
    logic          apply_s;
    logic          accept_s;
    logic [1:0]    out_mode_s;
    logic [7:0]    out_amp_s;

    assign {wrap_s, phase_sum_s} = {1'b0, phase_q} + {1'b0, fword_q};
    assign tick_s     = da_clk_q && (div_cnt_q == DIV_LAST);
    assign accept_s   = cfg_valid && ready_q;
    assign apply_s    = tick_s && pend_q && (!en || wrap_s || (mode_q == MODE_DC));
    assign out_mode_s = apply_s ? pend_mode_q : mode_q;
    assign out_amp_s  = apply_s ? pend_amp_q : amp_q;

    // Next-state: divider, sample path on ticks, config pending/apply.
    always_comb begin
        div_cnt_d    = div_cnt_q;
        da_clk_d     = da_clk_q;
        phase_d      = phase_q;
        data_d       = data_q;
        sync_d       = 1'b0;
        mode_d       = mode_q;
        fword_d      = fword_q;
        amp_d        = amp_q;
        pend_d       = pend_q;
        pend_mode_d  = pend_mode_q;
        pend_fword_d = pend_fword_q;
        pend_amp_d   = pend_amp_q;

        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = {CW{1'b0}};
            da_clk_d  = ~da_clk_q;
        end else begin
            div_cnt_d = div_cnt_q + CW'(1);
            da_clk_d  = da_clk_q;
        end

        if (tick_s && en) begin
            phase_d = phase_sum_s;
            data_d  = wave_sample(out_mode_s, phase_sum_s[31:24], out_amp_s);
            sync_d  = wrap_s;
        end else if (tick_s) begin
            phase_d = 32'd0;
            data_d  = 8'd128;
            sync_d  = 1'b0;
        end else begin
            phase_d = phase_q;
            data_d  = data_q;
            sync_d  = 1'b0;
        end

        // Apply and accept are exclusive: accept needs ready, apply needs a pending entry.
        if (apply_s) begin
            mode_d  = pend_mode_q;
            fword_d = pend_fword_q;
            amp_d   = pend_amp_q;
            pend_d  = 1'b0;
        end else if (accept_s) begin
            pend_d       = 1'b1;
            pend_mode_d  = cfg_mode;
            pend_fword_d = cfg_fword;
            pend_amp_d   = cfg_amp;
        end else begin
            pend_d = pend_q;
        end

        ready_d = ~pend_d;
    end

    // State registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            div_cnt_q    <= {CW{1'b0}};
            da_clk_q     <= 1'b0;
            phase_q      <= 32'd0;
            mode_q       <= RST_MODE;
            fword_q      <= RST_FWORD;
            amp_q        <= RST_AMP;
            pend_q       <= 1'b0;
            pend_mode_q  <= 2'b00;
            pend_fword_q <= 32'd0;
            pend_amp_q   <= 8'd0;
            data_q       <= 8'd128;
            sync_q       <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            div_cnt_q    <= div_cnt_d;
            da_clk_q     <= da_clk_d;
            phase_q      <= phase_d;
            mode_q       <= mode_d;
            fword_q      <= fword_d;
            amp_q        <= amp_d;
            pend_q       <= pend_d;
            pend_mode_q  <= pend_mode_d;
            pend_fword_q <= pend_fword_d;
            pend_amp_q   <= pend_amp_d;
            data_q       <= data_d;
            sync_q       <= sync_d;
            ready_q      <= ready_d;
        end
    end

    assign da_clk    = da_clk_q;
    assign da_data   = data_q;
    assign wave_sync = sync_q;
    assign cfg_ready = ready_q;

endmodule
